// File: rtl/cond_flag_unit_if.sv
// cond_flag_unit_if
//   Groups the flag unit's ALU, bus and sequencer control signals.
//   slave  : the flag unit itself.
//   master : whoever drives the controls, which is the sequencer or ALU side.
//   Signal names are the original port names of the flat module.
//   o_bus is a net rather than a variable because it floats when not enabled.
interface cond_flag_unit_if;
    logic       i_flagNegative;
    logic       i_flagNZero;
    logic       i_flagOverflow;
    logic       i_flagCarry;
    logic       i_ctrlAluYNWE;
    logic [7:0] i_bus;
    tri   [7:0] o_bus;
    logic       i_ctrlFlagNWE;
    logic       i_ctrlFlagNOE;
    logic       i_ctrlFlagPush;
    logic       i_ctrlFlagPop;
    logic       i_ctrlCondEval;
    logic [3:0] i_cond;
    logic [3:0] o_flags;
    logic       o_jump;
    logic       o_stackErr;

    modport master (
        output i_flagNegative, i_flagNZero, i_flagOverflow, i_flagCarry,
        output i_ctrlAluYNWE, i_bus, i_ctrlFlagNWE, i_ctrlFlagNOE,
        output i_ctrlFlagPush, i_ctrlFlagPop, i_ctrlCondEval, i_cond,
        input  o_bus, o_flags, o_jump, o_stackErr
    );

    modport slave (
        input  i_flagNegative, i_flagNZero, i_flagOverflow, i_flagCarry,
        input  i_ctrlAluYNWE, i_bus, i_ctrlFlagNWE, i_ctrlFlagNOE,
        input  i_ctrlFlagPush, i_ctrlFlagPop, i_ctrlCondEval, i_cond,
        output o_bus, o_flags, o_jump, o_stackErr
    );
endinterface

// File: rtl/cond_flag_unit.sv
// cond_flag_unit
//   Architectural flag register F = {N, NZ, V, C} downstream of the 8-bit ALU,
//   with bus save/restore, an optional flag stack for interrupt entry/exit and
//   a registered branch-condition evaluator.
//
//   Ports:
//     i_clk    : clock, rising edge
//     i_reset  : synchronous, active-high reset
//     cf       : cond_flag_unit_if.slave (ALU flags, ALU write strobe, data
//                bus in/out, flag restore/output enables, push/pop, condition
//                evaluate + code, o_flags, o_jump, o_stackErr)
//   Parameter:
//     STACK_DEPTH : number of flag-stack entries
//   Build option:
//     COND_FLAG_STACK_EN : when defined the flag stack, push/pop and the sticky
//                          o_stackErr are built; otherwise push/pop are ignored
//                          and o_stackErr is tied low.
module cond_flag_unit #(
    parameter int unsigned STACK_DEPTH = 4
) (
    input logic         i_clk,
    input logic         i_reset,
    cond_flag_unit_if.slave cf
);

    typedef enum logic [3:0] {
        COND_ALWAYS = 4'h0,
        COND_Z      = 4'h1,
        COND_NZ     = 4'h2,
        COND_C      = 4'h3,
        COND_NC     = 4'h4,
        COND_N      = 4'h5,
        COND_NN     = 4'h6,
        COND_V      = 4'h7,
        COND_NV     = 4'h8,
        COND_UGT    = 4'h9,
        COND_ULE    = 4'hA,
        COND_SGE    = 4'hB,
        COND_SLT    = 4'hC,
        COND_SGT    = 4'hD,
        COND_SLE    = 4'hE,
        COND_NEVER  = 4'hF
    } cond_e;

    logic [3:0] flags_q;
    logic       r_aluUpd;
    logic       jump_q;
    logic       cond_hit;
    logic       pop_ok;
    logic [3:0] pop_val;

    // ------------------------------------------------------------------
    // Flag stack
    // ------------------------------------------------------------------
`ifdef COND_FLAG_STACK_EN
    localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [3:0]     stack_mem [STACK_DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_dec;
    logic           err_q;
    logic           push_only;
    logic           pop_only;
    logic           stack_full;
    logic           stack_empty;
    logic [3:0]     unused_bits;

    assign unused_bits = cf.i_bus[7:4];

    always_comb begin
        // Simultaneous push and pop cancel each other entirely.
        push_only   = cf.i_ctrlFlagPush & ~cf.i_ctrlFlagPop;
        pop_only    = cf.i_ctrlFlagPop & ~cf.i_ctrlFlagPush;
        stack_full  = (sp == SPW'(STACK_DEPTH));
        stack_empty = (sp == '0);
        sp_dec      = sp - SPW'(1);
        pop_ok      = pop_only & ~stack_empty;
        pop_val     = stack_mem[sp_dec[IW-1:0]];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else begin
            if (push_only) begin
                if (stack_full) err_q <= 1'b1;
                else            sp    <= sp + SPW'(1);
            end
            if (pop_only) begin
                if (stack_empty) err_q <= 1'b1;
                else             sp    <= sp_dec;
            end
        end
    end

    // Storage has no reset; the pointer alone defines valid entries.
    // A push always stores F as it was before this edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset && push_only && !stack_full)
            stack_mem[sp[IW-1:0]] <= flags_q;
    end

    assign cf.o_stackErr = err_q;
`else
    logic unused_stack;

    assign unused_stack  = ^{cf.i_ctrlFlagPush, cf.i_ctrlFlagPop,
                             cf.i_bus[7:4], STACK_DEPTH[0]};
    assign pop_ok        = 1'b0;
    assign pop_val       = '0;
    assign cf.o_stackErr = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Flag register: reset > pop > bus restore > ALU capture > hold
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            flags_q  <= '0;
            r_aluUpd <= 1'b0;
        end else begin
            // ALU flags are registered by the ALU on the strobe edge, so they
            // are captured one edge later.
            r_aluUpd <= ~cf.i_ctrlAluYNWE;
            if (pop_ok)
                flags_q <= pop_val;
            else if (!cf.i_ctrlFlagNWE)
                flags_q <= cf.i_bus[3:0];
            else if (r_aluUpd)
                flags_q <= {cf.i_flagNegative, cf.i_flagNZero,
                            cf.i_flagOverflow, cf.i_flagCarry};
        end
    end

    // ------------------------------------------------------------------
    // Condition evaluation on F before the edge
    // ------------------------------------------------------------------
    always_comb begin
        logic n, z, v, c;
        n        = flags_q[3];
        z        = ~flags_q[2];
        v        = flags_q[1];
        c        = flags_q[0];
        cond_hit = 1'b0;
        case (cond_e'(cf.i_cond))
            COND_ALWAYS: cond_hit = 1'b1;
            COND_Z:      cond_hit = z;
            COND_NZ:     cond_hit = ~z;
            COND_C:      cond_hit = c;
            COND_NC:     cond_hit = ~c;
            COND_N:      cond_hit = n;
            COND_NN:     cond_hit = ~n;
            COND_V:      cond_hit = v;
            COND_NV:     cond_hit = ~v;
            COND_UGT:    cond_hit = c & ~z;
            COND_ULE:    cond_hit = ~c | z;
            COND_SGE:    cond_hit = ~(n ^ v);
            COND_SLT:    cond_hit = n ^ v;
            COND_SGT:    cond_hit = ~z & ~(n ^ v);
            COND_SLE:    cond_hit = z | (n ^ v);
            COND_NEVER:  cond_hit = 1'b0;
            default:     cond_hit = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            jump_q <= 1'b0;
        else if (cf.i_ctrlCondEval)
            jump_q <= cond_hit;
    end

    assign cf.o_flags = flags_q;
    assign cf.o_jump  = jump_q;
    assign cf.o_bus   = cf.i_ctrlFlagNOE ? 'z : {4'b0000, flags_q};

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cond_flag_unit_if cf();

    cond_flag_unit #(.STACK_DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .cf      (cf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [3:0] m_f       = 4'h0;
    logic       m_jump    = 1'b0;
    logic       m_err     = 1'b0;
    logic       m_alu_upd = 1'b0;
    logic [3:0] m_stack[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A released bus reads as all-Z, or as 0 where Z resolves to 0.
    function automatic logic bus_released();
        return (cf.o_bus === 8'hzz) || (cf.o_bus === 8'h00);
    endfunction

    // Branch conditions from the flag meanings: Z = !NZ, C = no borrow.
    function automatic logic cond_true(input logic [3:0] code, input logic [3:0] f);
        bit n, z, v, c;
        n = f[3]; z = !f[2]; v = f[1]; c = f[0];
        case (code)
            4'h0: return 1'b1;
            4'h1: return z;
            4'h2: return !z;
            4'h3: return c;
            4'h4: return !c;
            4'h5: return n;
            4'h6: return !n;
            4'h7: return v;
            4'h8: return !v;
            4'h9: return c && !z;
            4'hA: return !c || z;
            4'hB: return n == v;
            4'hC: return n != v;
            4'hD: return !z && (n == v);
            4'hE: return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        logic [3:0] f_old;
        logic [3:0] pv;
        bit popped;
        f_old  = m_f;
        pv     = 4'h0;
        popped = 0;
        if (reset) begin
            m_f = 4'h0; m_jump = 1'b0; m_err = 1'b0; m_alu_upd = 1'b0;
            m_stack.delete();
            return;
        end
`ifdef COND_FLAG_STACK_EN
        if (cf.i_ctrlFlagPush && !cf.i_ctrlFlagPop) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(f_old);
            else                        m_err = 1'b1;
        end
        if (cf.i_ctrlFlagPop && !cf.i_ctrlFlagPush) begin
            if (m_stack.size() > 0) begin pv = m_stack.pop_back(); popped = 1; end
            else                    m_err = 1'b1;
        end
`endif
        if (popped)                  m_f = pv;
        else if (!cf.i_ctrlFlagNWE)  m_f = cf.i_bus[3:0];
        else if (m_alu_upd)          m_f = {cf.i_flagNegative, cf.i_flagNZero,
                                            cf.i_flagOverflow, cf.i_flagCarry};
        if (cf.i_ctrlCondEval) m_jump = cond_true(cf.i_cond, f_old);
        m_alu_upd = !cf.i_ctrlAluYNWE;
    endtask

    // One clock edge, then compare every output against the model.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("flags", cf.o_flags, m_f);
        check("jump", cf.o_jump, m_jump);
        check("stack_err", cf.o_stackErr, m_err);
        if (cf.i_ctrlFlagNOE == 1'b0)
            check("bus_drive", cf.o_bus, {4'h0, m_f});
        else if (m_f != 4'h0)
            check("bus_float", bus_released(), 1'b1);
    endtask

    task automatic idle();
        reset             = 1'b0;
        cf.i_flagNegative = 1'b0;
        cf.i_flagNZero    = 1'b0;
        cf.i_flagOverflow = 1'b0;
        cf.i_flagCarry    = 1'b0;
        cf.i_ctrlAluYNWE  = 1'b1;
        cf.i_bus          = 8'h00;
        cf.i_ctrlFlagNWE  = 1'b1;
        cf.i_ctrlFlagNOE  = 1'b1;
        cf.i_ctrlFlagPush = 1'b0;
        cf.i_ctrlFlagPop  = 1'b0;
        cf.i_ctrlCondEval = 1'b0;
        cf.i_cond         = 4'h0;
    endtask

    task automatic set_f(input logic [3:0] v);
        idle();
        cf.i_bus         = {4'h0, v};
        cf.i_ctrlFlagNWE = 1'b0;
        cycle();
        idle();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cycle();
        idle();
    endtask

    initial begin
        logic [15:0] mask5;
        logic [15:0] maskA;
        mask5 = 16'h2B4D;
        maskA = 16'h4CB3;

        // Reset state
        do_reset();
        check("rst_flags", cf.o_flags, 4'h0);
        check("rst_jump", cf.o_jump, 1'b0);
        check("rst_err", cf.o_stackErr, 1'b0);

        // ALU capture lands two edges after the strobe
        cf.i_flagNegative = 1'b1;
        cf.i_flagNZero    = 1'b1;
        cf.i_ctrlAluYNWE  = 1'b0;
        cycle();
        cf.i_ctrlAluYNWE  = 1'b1;
        check("alu_not_yet", cf.o_flags, 4'h0);
        cycle();
        check("alu_capture", cf.o_flags, 4'hC);

        // Restore and bus readout
        set_f(4'h5);
        check("restore", cf.o_flags, 4'h5);
        cf.i_ctrlFlagNOE = 1'b0;
        #1;
        check("bus_out", cf.o_bus, 8'h05);
        cf.i_ctrlFlagNOE = 1'b1;
        #1;
        check("bus_release", bus_released(), 1'b1);

        // Condition sweeps
        for (int c = 0; c < 16; c++) begin
            cf.i_cond = 4'(c);
            cf.i_ctrlCondEval = 1'b1;
            cycle();
            check($sformatf("cond5_%0h", c), cf.o_jump, mask5[c]);
        end
        set_f(4'hA);
        for (int c = 0; c < 16; c++) begin
            cf.i_cond = 4'(c);
            cf.i_ctrlCondEval = 1'b1;
            cycle();
            check($sformatf("condA_%0h", c), cf.o_jump, maskA[c]);
        end
        idle();

        // Eval alongside a restore sees the old F (A has Z set)
        cf.i_bus = 8'h05;
        cf.i_ctrlFlagNWE = 1'b0;
        cf.i_ctrlCondEval = 1'b1;
        cf.i_cond = 4'h1;
        cycle();
        idle();
        check("eval_old_f", cf.o_jump, 1'b1);
        check("eval_restore_f", cf.o_flags, 4'h5);

`ifdef COND_FLAG_STACK_EN
        do_reset();
        for (int v = 1; v <= 4; v++) begin
            set_f(4'(v));
            cf.i_ctrlFlagPush = 1'b1;
            cycle();
            idle();
        end
        check("push_full_ok", cf.o_stackErr, 1'b0);
        cf.i_ctrlFlagPush = 1'b1;
        cycle();
        idle();
        check("push_overflow", cf.o_stackErr, 1'b1);
        for (int v = 4; v >= 1; v--) begin
            cf.i_ctrlFlagPop = 1'b1;
            cycle();
            idle();
            check($sformatf("pop_%0d", v), cf.o_flags, 4'(v));
        end
        cf.i_ctrlFlagPop = 1'b1;
        cycle();
        idle();
        check("pop_empty_f", cf.o_flags, 4'h1);
        check("pop_underflow", cf.o_stackErr, 1'b1);

        do_reset();
        set_f(4'h7);
        cf.i_ctrlFlagPush = 1'b1;
        cycle();
        set_f(4'h9);
        cf.i_ctrlFlagPush = 1'b1;
        cf.i_ctrlFlagPop  = 1'b1;
        cycle();
        idle();
        check("pushpop_f", cf.o_flags, 4'h9);
        check("pushpop_err", cf.o_stackErr, 1'b0);
        cf.i_ctrlFlagPop = 1'b1;
        cycle();
        idle();
        check("pushpop_stack", cf.o_flags, 4'h7);

        set_f(4'h9);
        cf.i_ctrlFlagPush = 1'b1;
        cycle();
        set_f(4'h3);
        cf.i_ctrlFlagPop = 1'b1;
        cf.i_bus = 8'h06;
        cf.i_ctrlFlagNWE = 1'b0;
        cycle();
        idle();
        check("pop_over_restore", cf.o_flags, 4'h9);
        check("pop_restore_err", cf.o_stackErr, 1'b0);
`else
        set_f(4'h5);
        cf.i_ctrlFlagPop = 1'b1;
        cycle();
        idle();
        check("nostack_pop", cf.o_flags, 4'h5);
        cf.i_ctrlFlagPush = 1'b1;
        cycle();
        idle();
        cf.i_ctrlFlagPop = 1'b1;
        cycle();
        idle();
        check("nostack_pushpop", cf.o_flags, 4'h5);
        check("nostack_err", cf.o_stackErr, 1'b0);
`endif

        // Reset the cycle after an ALU strobe drops the pending capture
        idle();
        cf.i_ctrlCondEval = 1'b1;
        cycle();
        idle();
        check("pre_rst_jump", cf.o_jump, 1'b1);
        cf.i_flagNegative = 1'b1;
        cf.i_flagNZero    = 1'b1;
        cf.i_flagOverflow = 1'b1;
        cf.i_flagCarry    = 1'b1;
        cf.i_ctrlAluYNWE  = 1'b0;
        cycle();
        cf.i_ctrlAluYNWE  = 1'b1;
        reset = 1'b1;
        cycle();
        check("mid_rst_flags", cf.o_flags, 4'h0);
        check("mid_rst_jump", cf.o_jump, 1'b0);
        reset = 1'b0;
        cycle();
        check("mid_rst_nocap", cf.o_flags, 4'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset             = ($urandom_range(0, 59) == 0);
            cf.i_flagNegative = 1'($urandom_range(0, 1));
            cf.i_flagNZero    = 1'($urandom_range(0, 1));
            cf.i_flagOverflow = 1'($urandom_range(0, 1));
            cf.i_flagCarry    = 1'($urandom_range(0, 1));
            cf.i_ctrlAluYNWE  = ($urandom_range(0, 2) != 0);
            cf.i_bus          = 8'($urandom);
            cf.i_ctrlFlagNWE  = ($urandom_range(0, 3) != 0);
            cf.i_ctrlFlagNOE  = 1'($urandom_range(0, 1));
            cf.i_ctrlFlagPush = ($urandom_range(0, 3) == 0);
            cf.i_ctrlFlagPop  = ($urandom_range(0, 3) == 0);
            cf.i_ctrlCondEval = 1'($urandom_range(0, 1));
            cf.i_cond         = 4'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
